instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-003 The block SHALL have the ports below, one per line (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  word-aligned read address; always equals PC.
- imem_valid  in  1  read data valid, ≥1 cycle after the request.
- imem_rdata  in  32  instruction word.
- Instr  out  32  held instruction register.
- Cond  out  4  Instr[31:28].
- Op  out  2  Instr[27:26].
- Funct  out  6  Instr[25:20].
- Rd  out  4  Instr[15:12].
- instr_valid  out  1  Instr holds an unissued instruction.
- issue_ready  in  1  downstream consumes Instr this cycle.
- PCSrc  in  1  branch/PC-write taken, from the control unit.
- Result  in  32  redirect target when PCSrc=1.
- PC  out  32  address of the instruction in Instr.
- PCPlus4  out  32  PC+4.
- PCPlus8  out  32  PC+8, the architectural PC read value.
- issued_count  out  32  number of instructions issued since reset.

Function
REQ-004 The block SHALL implement a 3-state FSM with states IDLE, FETCH and ISSUE.
REQ-005 In IDLE, the block SHALL drive imem_req=0 and instr_valid=0, ignore imem_valid, and go to FETCH on the next cycle.
REQ-006 In FETCH, the block SHALL drive imem_req=1 and imem_addr=PC, and hold both stable until imem_valid=1.
REQ-007 In FETCH with imem_valid=1, the block SHALL capture Instr<=imem_rdata and go to ISSUE; instr_valid SHALL be 1 from the next cycle.
REQ-008 In ISSUE, the block SHALL drive instr_valid=1 and imem_req=0, and SHALL hold Instr, PC and the decoded fields stable while issue_ready=0.
REQ-009 The issue handshake SHALL occur when instr_valid=1 and issue_ready=1 in the same cycle.
REQ-010 On the issue handshake:
- PC SHALL load {Result[31:2],2'b00} if PCSrc=1, otherwise PC+4.
- issued_count SHALL increment by 1.
- the FSM SHALL go to FETCH.
REQ-011 PCSrc and Result SHALL be sampled only on the handshake cycle and ignored otherwise.
REQ-012 Minimum throughput SHALL be one instruction per 2 cycles with single-cycle memory: FETCH, then ISSUE.
REQ-013 imem_valid asserted while in IDLE or ISSUE SHALL be ignored; Instr SHALL be unchanged.
REQ-014 PC arithmetic SHALL be modulo 2^32:
- 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
- PCPlus4 and PCPlus8 SHALL be combinational from PC and wrap the same way.
REQ-015 PC[1:0] SHALL always be 2'b00.
REQ-016 issued_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-017 Cond, Op, Funct and Rd SHALL be pure combinational slices of Instr.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL set:
- state=IDLE
- PC=RESET_PC
- Instr=32'h0
- issued_count=0
- instr_valid=0
- imem_req=0
REQ-019 Reset SHALL take priority over every other event, including a simultaneous handshake or imem_valid.
REQ-020 Reset mid-fetch SHALL abandon the request; the instruction memory SHALL share rst and drop outstanding reads.
REQ-021 The first imem_req after reset release SHALL occur in the second cycle after rst deasserts, with imem_addr=RESET_PC.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release with RESET_PC=0, single-cycle memory, issue_ready=1 -> imem_addr sequence 0,4,8; instr_valid every 2nd cycle; issued_count=3 after 6 cycles in FETCH/ISSUE.
- Memory latency 3 cycles -> imem_req held high 3 cycles with imem_addr constant; Instr captured only on imem_valid.
- issue_ready=0 for 5 cycles in ISSUE -> Instr, PC and instr_valid stable; no new imem_req; issued_count unchanged.
- Handshake with PCSrc=1, Result=32'h0000_0103 at PC=32'h20 -> next imem_addr=32'h0000_0100; PCPlus8=32'h108 after the next capture.
- PC=32'hFFFF_FFFC, handshake with PCSrc=0 -> PC=0; PCPlus8 at PC=32'hFFFF_FFFC reads 32'h0000_0004.
- rst asserted in FETCH with imem_valid=1 in the same cycle -> Instr=0, instr_valid=0, PC=RESET_PC; spurious imem_valid in IDLE ignored.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch stage and the instruction memory.
// The fetch stage is the master; the memory answers with valid/rdata.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: requests the word at PC, holds it in Instr until issued,
// then advances PC sequentially or to a redirect target.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_if.master        imem,
    output logic [31:0]                Instr,
    output logic [3:0]                 Cond,
    output logic [1:0]                 Op,
    output logic [5:0]                 Funct,
    output logic [3:0]                 Rd,
    output logic                       instr_valid,
    input  logic                       issue_ready,
    input  logic                       PCSrc,
    input  logic [31:0]                Result,
    output logic [31:0]                PC,
    output logic [31:0]                PCPlus4,
    output logic [31:0]                PCPlus8,
    output logic [31:0]                issued_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        capture_s;
    logic        handshake_s;
    logic [31:0] pc_next_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] count_r;
    logic        req_r;
    logic        valid_r;

    // Next-state decode; capture and handshake strobes fall out of the state.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        handshake_s  = 1'b0;
        case (state_r)
            IDLE: begin
                next_state_s = FETCH;
            end
            FETCH: begin
                if (imem.imem_valid) begin
                    capture_s    = 1'b1;
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            ISSUE: begin
                if (valid_r && issue_ready) begin
                    handshake_s  = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Redirect target is forced word-aligned; sequential path wraps modulo 2^32.
    always_comb begin
        pc_next_s = pc_r + 32'd4;
        if (PCSrc) begin
            pc_next_s = Result & 32'hFFFF_FFFC;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // State, PC, instruction and issue counter; req/valid are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            count_r <= 32'h0000_0000;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            req_r   <= (next_state_s == FETCH);
            valid_r <= (next_state_s == ISSUE);
            if (capture_s) begin
                instr_r <= imem.imem_rdata;
            end
            if (handshake_s) begin
                pc_r    <= pc_next_s;
                count_r <= count_r + 32'd1;
            end
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign instr_valid    = valid_r;
    assign Instr          = instr_r;
    assign PC             = pc_r;
    assign PCPlus4        = pc_r + 32'd4;
    assign PCPlus8        = pc_r + 32'd8;
    assign issued_count   = count_r;
    assign Cond           = instr_r[31:28];
    assign Op             = instr_r[27:26];
    assign Funct          = instr_r[25:20];
    assign Rd             = instr_r[15:12];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small latency-programmable memory model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        issue_ready;
    logic        PCSrc;
    logic [31:0] Result;
    logic [31:0] Instr;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] PCPlus8;
    logic [31:0] issued_count;

    logic [1:0]  lat;
    logic [1:0]  wcnt;
    logic        spurious;
    int          n_cmp;
    int          n_err;

    instruction_fetch_if imem ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem),
        .Instr        (Instr),
        .Cond         (Cond),
        .Op           (Op),
        .Funct        (Funct),
        .Rd           (Rd),
        .instr_valid  (instr_valid),
        .issue_ready  (issue_ready),
        .PCSrc        (PCSrc),
        .Result       (Result),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .PCPlus8      (PCPlus8),
        .issued_count (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data = addr ^ C5A3_F0F0, valid after lat cycles of request.
    assign imem.imem_rdata = imem.imem_addr ^ 32'hC5A3_F0F0;
    assign imem.imem_valid = (imem.imem_req && (wcnt >= (lat - 2'd1))) || spurious;

    always @(posedge clk) begin
        if (rst) wcnt <= 2'd0;
        else if (imem.imem_req && !imem.imem_valid) wcnt <= wcnt + 2'd1;
        else wcnt <= 2'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; issue_ready = 1'b1; PCSrc = 1'b0; Result = 32'h0;
        lat = 2'd1; spurious = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_count", issued_count, 32'h0);
        rst = 1'b0;
        chk("rel_cyc1_req", {31'd0, imem.imem_req}, 32'd0);

        // Single-cycle memory, back-to-back issue
        step();
        chk("f0_req", {31'd0, imem.imem_req}, 32'd1);
        chk("f0_addr", imem.imem_addr, 32'h0);
        chk("f0_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("i0_valid", {31'd0, instr_valid}, 32'd1);
        chk("i0_req", {31'd0, imem.imem_req}, 32'd0);
        chk("i0_instr", Instr, 32'hC5A3_F0F0);
        chk("i0_pc", PC, 32'h0);
        chk("i0_cond", {28'd0, Cond}, 32'hC);
        chk("i0_op", {30'd0, Op}, 32'h1);
        chk("i0_funct", {26'd0, Funct}, 32'h1A);
        chk("i0_rd", {28'd0, Rd}, 32'hF);
        step();
        chk("f1_addr", imem.imem_addr, 32'h4);
        chk("f1_count", issued_count, 32'd1);
        chk("f1_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("i1_instr", Instr, 32'hC5A3_F0F4);
        step();
        chk("f2_addr", imem.imem_addr, 32'h8);
        chk("f2_count", issued_count, 32'd2);
        step();
        chk("i2_instr", Instr, 32'hC5A3_F0F8);
        lat = 2'd3;

        // Three-cycle memory latency
        step();
        chk("lat_count", issued_count, 32'd3);
        chk("lat1_req", {31'd0, imem.imem_req}, 32'd1);
        chk("lat1_addr", imem.imem_addr, 32'hC);
        step();
        chk("lat2_req", {31'd0, imem.imem_req}, 32'd1);
        chk("lat2_addr", imem.imem_addr, 32'hC);
        chk("lat2_instr", Instr, 32'hC5A3_F0F8);
        step();
        chk("lat3_req", {31'd0, imem.imem_req}, 32'd1);
        chk("lat3_addr", imem.imem_addr, 32'hC);
        chk("lat3_instr", Instr, 32'hC5A3_F0F8);
        issue_ready = 1'b0;
        step();
        chk("lat_cap_instr", Instr, 32'hC5A3_F0FC);
        chk("lat_cap_valid", {31'd0, instr_valid}, 32'd1);

        // Stall in ISSUE with spurious valid and non-handshake redirect
        spurious = 1'b1; PCSrc = 1'b1; Result = 32'hDEAD_BEE0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_instr", Instr, 32'hC5A3_F0FC);
            chk("stall_pc", PC, 32'hC);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem.imem_req}, 32'd0);
            chk("stall_count", issued_count, 32'd3);
        end
        spurious = 1'b0; Result = 32'h0000_0022; issue_ready = 1'b1; lat = 2'd1;

        // Redirects: to 0x20, then 0x103 -> 0x100
        step();
        chk("rd20_addr", imem.imem_addr, 32'h20);
        chk("rd20_count", issued_count, 32'd4);
        step();
        chk("rd20_pc", PC, 32'h20);
        chk("rd20_instr", Instr, 32'hC5A3_F0D0);
        Result = 32'h0000_0103;
        step();
        chk("rd100_addr", imem.imem_addr, 32'h100);
        chk("rd100_count", issued_count, 32'd5);
        step();
        chk("rd100_instr", Instr, 32'hC5A3_F1F0);
        chk("rd100_pc8", PCPlus8, 32'h108);
        chk("rd100_pc4", PCPlus4, 32'h104);
        chk("rd100_rd", {28'd0, Rd}, 32'hF);
        Result = 32'hFFFF_FFFF;

        // Top-of-address-space wrap
        step();
        chk("top_addr", imem.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("top_pc", PC, 32'hFFFF_FFFC);
        chk("top_pc4", PCPlus4, 32'h0);
        chk("top_pc8", PCPlus8, 32'h4);
        chk("top_instr", Instr, 32'h3A5C_0F0C);
        chk("top_cond", {28'd0, Cond}, 32'h3);
        PCSrc = 1'b0;
        step();
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_addr", imem.imem_addr, 32'h0);
        chk("wrap_count", issued_count, 32'd7);

        // Reset in FETCH with imem_valid high, then spurious valid in IDLE
        lat = 2'd3; rst = 1'b1; spurious = 1'b1;
        step();
        chk("mrst_instr", Instr, 32'h0);
        chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mrst_pc", PC, 32'h0);
        chk("mrst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("mrst_count", issued_count, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_sp_instr", Instr, 32'h0);
        chk("idle_sp_valid", {31'd0, instr_valid}, 32'd0);
        chk("idle_sp_req", {31'd0, imem.imem_req}, 32'd1);
        spurious = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
